// File: rtl/word_serializer.sv
// ---------------------------------------------------------------------------
// word_serializer
//
// Purpose:
//   Accepts a WIDTH-bit parallel word and shifts it out one bit per clock,
//   LSB first. One extra word can be parked in a holding buffer while the
//   current word is shifting. Back-to-back words are emitted with no gap.
//   The serial stream drives a downstream serial two's-complement stage:
//   i_out is its data input and sof is its per-word reset.
//
// Ports:
//   t_clk        in   1      clock; all state changes on the rising edge
//   r            in   1      synchronous, active-high reset
//   load         in   1      request to accept din at this edge
//   din          in   WIDTH  parallel word to serialize
//   ready        out  1      a load at this edge will be accepted
//   i_out        out  1      serial data bit (registered)
//   sof          out  1      high during bit 0 of every word (registered)
//   valid        out  1      high while i_out carries a word bit (registered)
//   done         out  1      high during bit WIDTH-1 of a word (registered)
//   o_dbg_state  out  1      shifter state: 0 = IDLE, 1 = SHIFT
//
// Handshake:
//   A word is accepted on a rising edge where load && ready are both high.
//   ready depends only on reset and on the holding buffer being empty, never
//   on load, so there is no combinational loop with the producer. A load
//   while ready is low is dropped and its din is discarded.
// ---------------------------------------------------------------------------
module word_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             t_clk,
  input  logic             r,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             i_out,
  output logic             sof,
  output logic             valid,
  output logic             done,
  output logic             o_dbg_state
);

  // Bit counter just wide enough to index WIDTH-1 (WIDTH >= 2, so CW >= 1).
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;      // remaining bits of the current word, bit 0 on the line
  logic [WIDTH-1:0] r_hold_data;
  logic             r_hold_valid;
  logic             r_out;
  logic             r_sof;
  logic             r_valid;
  logic             r_done;

  // -------------------------------------------------------------------------
  // Next-state wires
  // -------------------------------------------------------------------------
  state_t           w_state_n;
  logic [CW-1:0]    w_cnt_n;
  logic [WIDTH-1:0] w_shift_n;
  logic [WIDTH-1:0] w_hold_data_n;
  logic             w_hold_valid_n;
  logic             w_out_n;
  logic             w_sof_n;
  logic             w_valid_n;
  logic             w_done_n;
  logic             w_accept;
  logic             w_last;

  assign ready    = !r && !r_hold_valid;
  assign w_accept = load && ready;
  assign w_last   = (r_state == S_SHIFT) && (r_cnt == LAST_BIT);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_n      = r_state;
    w_cnt_n        = r_cnt;
    w_shift_n      = r_shift;
    w_hold_data_n  = r_hold_data;
    w_hold_valid_n = r_hold_valid;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_n = S_SHIFT;
          w_shift_n = din;
          w_cnt_n   = '0;
        end
      end

      S_SHIFT: begin
        if (w_last) begin
          // Word boundary: chain from the buffer first, then a fresh accept
          // (only possible when the buffer is empty), otherwise go idle.
          if (r_hold_valid) begin
            w_shift_n      = r_hold_data;
            w_cnt_n        = '0;
            w_hold_valid_n = 1'b0;
          end else if (w_accept) begin
            w_shift_n = din;
            w_cnt_n   = '0;
          end else begin
            w_state_n = S_IDLE;
            w_shift_n = '0;
            w_cnt_n   = '0;
          end
        end else begin
          w_shift_n = r_shift >> 1;
          w_cnt_n   = r_cnt + 1'b1;
          if (w_accept) begin
            w_hold_data_n  = din;
            w_hold_valid_n = 1'b1;
          end
        end
      end

      default: begin
        w_state_n = S_IDLE;
        w_shift_n = '0;
        w_cnt_n   = '0;
      end
    endcase
  end

  // Output flags are derived from the next state so they can be registered
  // and line up with the bit that appears on i_out in the same cycle.
  always_comb begin
    w_valid_n = (w_state_n == S_SHIFT);
    w_out_n   = w_valid_n && w_shift_n[0];
    w_sof_n   = w_valid_n && (w_cnt_n == '0);
    w_done_n  = w_valid_n && (w_cnt_n == LAST_BIT);
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge t_clk) begin
    if (r) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_hold_data  <= '0;
      r_hold_valid <= 1'b0;
      r_out        <= 1'b0;
      r_sof        <= 1'b0;
      r_valid      <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_cnt        <= w_cnt_n;
      r_shift      <= w_shift_n;
      r_hold_data  <= w_hold_data_n;
      r_hold_valid <= w_hold_valid_n;
      r_out        <= w_out_n;
      r_sof        <= w_sof_n;
      r_valid      <= w_valid_n;
      r_done       <= w_done_n;
    end
  end

  assign i_out       = r_out;
  assign sof         = r_sof;
  assign valid       = r_valid;
  assign done        = r_done;
  assign o_dbg_state = (r_state == S_SHIFT);

  // -------------------------------------------------------------------------
  // Embedded invariants
  // -------------------------------------------------------------------------
  a_cnt_range : assert property (@(posedge t_clk) disable iff (r)
    r_cnt <= LAST_BIT);
  a_sof_valid : assert property (@(posedge t_clk) disable iff (r)
    sof |-> valid);
  a_done_valid : assert property (@(posedge t_clk) disable iff (r)
    done |-> valid);
  a_idle_quiet : assert property (@(posedge t_clk) disable iff (r)
    (r_state == S_IDLE) |-> (!valid && !i_out && !sof && !done && !r_hold_valid));

endmodule

// File: tb/tb_word_serializer.sv
module tb_word_serializer;

  logic       clk;
  logic       r;
  logic       load8;
  logic [7:0] din8;
  logic       ready8, i_out8, sof8, valid8, done8, st8;
  logic       load4;
  logic [3:0] din4;
  logic       ready4, i_out4, sof4, valid4, done4, st4;

  int n_checks;
  int n_bad;

  logic [7:0] exp8_q[$];
  logic [7:0] got8_q[$];
  logic [3:0] exp4_q[$];
  logic [3:0] got4_q[$];

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  word_serializer #(.WIDTH(8)) dut8 (
    .t_clk(clk), .r(r), .load(load8), .din(din8), .ready(ready8),
    .i_out(i_out8), .sof(sof8), .valid(valid8), .done(done8), .o_dbg_state(st8)
  );

  word_serializer #(.WIDTH(4)) dut4 (
    .t_clk(clk), .r(r), .load(load4), .din(din4), .ready(ready4),
    .i_out(i_out4), .sof(sof4), .valid(valid4), .done(done4), .o_dbg_state(st4)
  );

  // ---------------- output monitors: rebuild words from the serial stream ----------------
  int         mon8_cnt;
  logic [7:0] mon8_word;
  int         mon4_cnt;
  logic [3:0] mon4_word;

  always @(negedge clk) begin
    if (r) begin
      mon8_cnt = 0;
    end else if (valid8) begin
      if (sof8) mon8_cnt = 0;
      if (mon8_cnt < 8) mon8_word[mon8_cnt] = i_out8;
      if (done8) begin
        got8_q.push_back(mon8_word);
        mon8_cnt = 0;
      end else begin
        mon8_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (r) begin
      mon4_cnt = 0;
    end else if (valid4) begin
      if (sof4) mon4_cnt = 0;
      if (mon4_cnt < 4) mon4_word[mon4_cnt] = i_out4;
      if (done4) begin
        got4_q.push_back(mon4_word);
        mon4_cnt = 0;
      end else begin
        mon4_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Sample point in the middle of the cycle; record accepted words.
  task automatic sample();
    @(negedge clk);
    if (load8 && ready8) exp8_q.push_back(din8);
    if (load4 && ready4) exp4_q.push_back(din4);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    r = 1'b1; load8 = 1'b0; din8 = '0; load4 = 1'b0; din4 = '0;
    advance();
    sample();
    n_checks++;
    if ({ready8, valid8, sof8, done8, i_out8} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset8: got %b want 00000", {ready8, valid8, sof8, done8, i_out8});
    end
    n_checks++;
    if ({ready4, valid4, sof4, done4, i_out4} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset4: got %b want 00000", {ready4, valid4, sof4, done4, i_out4});
    end
    advance();
    r = 1'b0;
    sample();
    n_checks++;
    if ({ready8, valid8, sof8, done8, i_out8} !== 5'b10000) begin
      n_bad++;
      $display("FAIL release8: got %b want 10000", {ready8, valid8, sof8, done8, i_out8});
    end
    advance();
  endtask

  task automatic test_single();
    logic [7:0] w;
    logic [4:0] exp_v;
    int k;
    w = 8'hB4;
    load8 = 1'b1; din8 = w;
    sample();
    advance();
    load8 = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      din8 = 8'($urandom);
      sample();
      k = (c - 1) % 8;
      exp_v = (c <= 8) ? {1'b1, 1'b1, k == 0, k == 7, w[k]} : 5'b10000;
      n_checks++;
      if ({ready8, valid8, sof8, done8, i_out8} !== exp_v) begin
        n_bad++;
        $display("FAIL single c%0d: got %b want %b", c, {ready8, valid8, sof8, done8, i_out8}, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    logic [4:0] exp_v;
    int k;
    load8 = 1'b1; din8 = 8'hB4;
    sample();
    advance();
    load8 = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      sample();
      k = (c - 1) % 8;
      w = (c <= 8) ? 8'hB4 : 8'h0F;
      exp_v = (c <= 16) ? {!(c >= 5 && c <= 8), 1'b1, k == 0, k == 7, w[k]}
                        : 5'b10000;
      n_checks++;
      if ({ready8, valid8, sof8, done8, i_out8} !== exp_v) begin
        n_bad++;
        $display("FAIL b2b c%0d: got %b want %b", c, {ready8, valid8, sof8, done8, i_out8}, exp_v);
      end
      advance();
      load8 = (c + 1 == 4);
      din8  = (c + 1 == 4) ? 8'h0F : 8'($urandom);
    end
    load8 = 1'b0;
  endtask

  task automatic test_overflow();
    logic [7:0] w;
    logic [4:0] exp_v;
    int k;
    load8 = 1'b1; din8 = 8'h01;
    sample();
    advance();
    load8 = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      sample();
      k = (c - 1) % 8;
      w = (c <= 8) ? 8'h01 : 8'h02;
      exp_v = (c <= 16) ? {!(c >= 3 && c <= 8), 1'b1, k == 0, k == 7, w[k]}
                        : 5'b10000;
      n_checks++;
      if ({ready8, valid8, sof8, done8, i_out8} !== exp_v) begin
        n_bad++;
        $display("FAIL overflow c%0d: got %b want %b", c, {ready8, valid8, sof8, done8, i_out8}, exp_v);
      end
      advance();
      load8 = (c + 1 == 2) || (c + 1 == 4);
      din8  = (c + 1 == 2) ? 8'h02 : 8'h03;
    end
    load8 = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [7:0] w;
    logic [4:0] exp_v;
    int k;
    load8 = 1'b1; din8 = 8'hFF;
    sample();
    advance();
    load8 = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      sample();
      k = (c - 1) % 8;
      w = (c <= 8) ? 8'hFF : 8'h80;
      exp_v = (c <= 16) ? {1'b1, 1'b1, k == 0, k == 7, w[k]} : 5'b10000;
      n_checks++;
      if ({ready8, valid8, sof8, done8, i_out8} !== exp_v) begin
        n_bad++;
        $display("FAIL simul c%0d: got %b want %b", c, {ready8, valid8, sof8, done8, i_out8}, exp_v);
      end
      advance();
      load8 = (c + 1 == 8);
      din8  = (c + 1 == 8) ? 8'h80 : 8'($urandom);
    end
    load8 = 1'b0;
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w;
    logic [4:0] exp_v;
    int k;
    w = 8'hAA;
    load8 = 1'b1; din8 = w;
    sample();
    advance();
    load8 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      sample();
      k = c - 1;
      if (c <= 5) exp_v = {c != 5, 1'b1, k == 0, 1'b0, w[k]};
      else        exp_v = 5'b10000;
      n_checks++;
      if ({ready8, valid8, sof8, done8, i_out8} !== exp_v) begin
        n_bad++;
        $display("FAIL rst_mid c%0d: got %b want %b", c, {ready8, valid8, sof8, done8, i_out8}, exp_v);
      end
      advance();
      r     = (c + 1 == 5);
      load8 = (c + 1 == 5);
      din8  = 8'h33;
    end
    // The aborted word never completes, so it leaves the expected stream.
    void'(exp8_q.pop_back());
    w = 8'h55;
    load8 = 1'b1; din8 = w;
    sample();
    advance();
    load8 = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      sample();
      k = (c - 1) % 8;
      exp_v = (c <= 8) ? {1'b1, 1'b1, k == 0, k == 7, w[k]} : 5'b10000;
      n_checks++;
      if ({ready8, valid8, sof8, done8, i_out8} !== exp_v) begin
        n_bad++;
        $display("FAIL rst_after c%0d: got %b want %b", c, {ready8, valid8, sof8, done8, i_out8}, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_width4_chain();
    logic [3:0] w;
    logic [4:0] exp_v;
    int k;
    load4 = 1'b1; din4 = 4'h9;
    sample();
    advance();
    load4 = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      sample();
      k = (c - 1) % 4;
      w = (c <= 4) ? 4'h9 : 4'h6;
      exp_v = (c <= 8) ? {!(c >= 3 && c <= 4), 1'b1, k == 0, k == 3, w[k]}
                       : 5'b10000;
      n_checks++;
      if ({ready4, valid4, sof4, done4, i_out4} !== exp_v) begin
        n_bad++;
        $display("FAIL w4 c%0d: got %b want %b", c, {ready4, valid4, sof4, done4, i_out4}, exp_v);
      end
      advance();
      load4 = (c + 1 == 2);
      din4  = (c + 1 == 2) ? 4'h6 : 4'($urandom_range(0, 15));
    end
    load4 = 1'b0;
  endtask

  task automatic test_scoreboard();
    logic [7:0] e8, g8;
    logic [3:0] e4, g4;
    n_checks++;
    if (got8_q.size() != exp8_q.size()) begin
      n_bad++;
      $display("FAIL sb8_count: got %0d words want %0d", got8_q.size(), exp8_q.size());
    end
    while (exp8_q.size() > 0 && got8_q.size() > 0) begin
      e8 = exp8_q.pop_front();
      g8 = got8_q.pop_front();
      n_checks++;
      if (g8 !== e8) begin
        n_bad++;
        $display("FAIL sb8_word: got %h want %h", g8, e8);
      end
    end
    n_checks++;
    if (got4_q.size() != exp4_q.size()) begin
      n_bad++;
      $display("FAIL sb4_count: got %0d words want %0d", got4_q.size(), exp4_q.size());
    end
    while (exp4_q.size() > 0 && got4_q.size() > 0) begin
      e4 = exp4_q.pop_front();
      g4 = got4_q.pop_front();
      n_checks++;
      if (g4 !== e4) begin
        n_bad++;
        $display("FAIL sb4_word: got %h want %h", g4, e4);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_bad    = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_simultaneous();
    test_reset_mid_word();
    test_width4_chain();
    advance();
    test_scoreboard();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
